// File: rtl/regfile_write_arbiter_if.sv
// Write-source and regfile write-port bundle for the register-file write arbiter.
// master: the requesting side (writeback, multdiv, IO); slave: the arbiter itself.
interface regfile_write_arbiter_if;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              wb_we;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;

    logic              md_valid;
    logic              md_ready;
    logic [REG_W-1:0]  md_reg;
    logic [DATA_W-1:0] md_data;

    logic              io_valid;
    logic              io_ready;
    logic [REG_W-1:0]  io_reg;
    logic [DATA_W-1:0] io_data;

    logic              stall_pipe;
    logic              ctrl_writeEnable;
    logic [REG_W-1:0]  ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic [1:0]        grant_src;

    modport master (
        output wb_we, wb_reg, wb_data,
        output md_valid, md_reg, md_data,
        output io_valid, io_reg, io_data,
        input  md_ready, io_ready,
        input  stall_pipe, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_src
    );

    modport slave (
        input  wb_we, wb_reg, wb_data,
        input  md_valid, md_reg, md_data,
        input  io_valid, io_reg, io_data,
        output md_ready, io_ready,
        output stall_pipe, ctrl_writeEnable, ctrl_writeReg, data_writeReg, grant_src
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single regfile write port between writeback, multdiv and IO.
// Writeback has priority; md/io alternate and a one-cycle pipeline stall bounds their wait.
module regfile_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_WB   = 2'b01;
    localparam logic [1:0] SRC_MD   = 2'b10;
    localparam logic [1:0] SRC_IO   = 2'b11;

    logic              rr_md_q, rr_md_nxt;
    logic [CNT_W-1:0]  wait_q, wait_nxt;
    logic              stall_q, stall_nxt;
    logic              we_q, we_nxt;
    logic [REG_W-1:0]  reg_q, reg_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic [1:0]        src_q, src_nxt;

    logic wb_win, side_valid, md_sel, md_go, io_go;

    // Grant selection and next-state of pointer, starvation counter and write port
    always_comb begin
        rr_md_nxt = rr_md_q;
        wait_nxt  = wait_q;
        stall_nxt = 1'b0;
        we_nxt    = 1'b0;
        reg_nxt   = reg_q;
        data_nxt  = data_q;
        src_nxt   = SRC_NONE;

        wb_win     = !stall_q && bus.wb_we && (bus.wb_reg != REG_W'(0));
        side_valid = bus.md_valid || bus.io_valid;
        md_sel     = bus.md_valid && (!bus.io_valid || rr_md_q);
        // No acceptance while reset is held, so requesters retry after release
        md_go      = !reset && !wb_win && md_sel;
        io_go      = !reset && !wb_win && bus.io_valid && !md_sel;

        if (wb_win) begin
            we_nxt   = 1'b1;
            reg_nxt  = bus.wb_reg;
            data_nxt = bus.wb_data;
            src_nxt  = SRC_WB;
        end else if (md_go) begin
            we_nxt    = (bus.md_reg != REG_W'(0));
            reg_nxt   = bus.md_reg;
            data_nxt  = bus.md_data;
            src_nxt   = SRC_MD;
            rr_md_nxt = 1'b0;
        end else if (io_go) begin
            we_nxt    = (bus.io_reg != REG_W'(0));
            reg_nxt   = bus.io_reg;
            data_nxt  = bus.io_data;
            src_nxt   = SRC_IO;
            rr_md_nxt = 1'b1;
        end

        if (!side_valid || md_go || io_go) begin
            wait_nxt = CNT_W'(0);
        end else if (wb_win) begin
            wait_nxt = wait_q + CNT_W'(1);
        end

        // Stalling forces a side grant next cycle, which clears the counter again
        stall_nxt = side_valid && wb_win && (wait_q == CNT_W'(STARVE_LIMIT - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_md_q <= 1'b1;
            wait_q  <= CNT_W'(0);
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            reg_q   <= REG_W'(0);
            data_q  <= DATA_W'(0);
            src_q   <= SRC_NONE;
        end else begin
            rr_md_q <= rr_md_nxt;
            wait_q  <= wait_nxt;
            stall_q <= stall_nxt;
            we_q    <= we_nxt;
            reg_q   <= reg_nxt;
            data_q  <= data_nxt;
            src_q   <= src_nxt;
        end
    end

    assign bus.md_ready         = md_go;
    assign bus.io_ready         = io_go;
    assign bus.stall_pipe       = stall_q;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = reg_q;
    assign bus.data_writeReg    = data_q;
    assign bus.grant_src        = src_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected write-port results are queued when
// each cycle's stimulus is applied and popped after the following clock edge.
module tb_regfile_write_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
        logic [1:0]  src;
        logic        stall;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check readies for the current inputs, queue the expected write, then check it after the edge
    task automatic step(input string tag, input logic mdr, input logic ior, input logic we,
                        input logic [4:0] r, input logic [31:0] d, input logic [1:0] src,
                        input logic st);
        exp_t e;
        #1;
        chk({tag, ".md_ready"}, 32'(bus.md_ready), 32'(mdr));
        chk({tag, ".io_ready"}, 32'(bus.io_ready), 32'(ior));
        sb.push_back('{we: we, r: r, d: d, src: src, stall: st});
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, ".we"},    32'(bus.ctrl_writeEnable), 32'(e.we));
        chk({tag, ".reg"},   32'(bus.ctrl_writeReg),    32'(e.r));
        chk({tag, ".data"},  bus.data_writeReg,         e.d);
        chk({tag, ".src"},   32'(bus.grant_src),        32'(e.src));
        chk({tag, ".stall"}, 32'(bus.stall_pipe),       32'(e.stall));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".we"},    32'(bus.ctrl_writeEnable), 32'd0);
        chk({tag, ".reg"},   32'(bus.ctrl_writeReg),    32'd0);
        chk({tag, ".data"},  bus.data_writeReg,         32'd0);
        chk({tag, ".src"},   32'(bus.grant_src),        32'd0);
        chk({tag, ".stall"}, 32'(bus.stall_pipe),       32'd0);
    endtask

    initial begin
        bus.wb_we = 1'b0; bus.wb_reg = 5'd0; bus.wb_data = 32'd0;
        bus.md_valid = 1'b0; bus.md_reg = 5'd0; bus.md_data = 32'd0;
        bus.io_valid = 1'b0; bus.io_reg = 5'd0; bus.io_data = 32'd0;
        #3;
        chk_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        // Lone writeback, then idle holds reg/data
        bus.wb_we = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'hA5A5_0001;
        step("wb", 0, 0, 1, 5'd5, 32'hA5A5_0001, 2'b01, 0);
        bus.wb_we = 1'b0;
        step("idle", 0, 0, 0, 5'd5, 32'hA5A5_0001, 2'b00, 0);

        // md and io both held: alternate starting with md
        bus.md_valid = 1'b1; bus.md_reg = 5'd6; bus.md_data = 32'h11;
        bus.io_valid = 1'b1; bus.io_reg = 5'd7; bus.io_data = 32'h22;
        step("rr1", 1, 0, 1, 5'd6, 32'h11, 2'b10, 0);
        bus.md_data = 32'h12;
        step("rr2", 0, 1, 1, 5'd7, 32'h22, 2'b11, 0);
        bus.io_data = 32'h23;
        step("rr3", 1, 0, 1, 5'd6, 32'h12, 2'b10, 0);
        step("rr4", 0, 1, 1, 5'd7, 32'h23, 2'b11, 0);
        bus.md_valid = 1'b0; bus.io_valid = 1'b0;

        // IO write to r0: accepted, not enabled
        bus.io_valid = 1'b1; bus.io_reg = 5'd0; bus.io_data = 32'h33;
        step("io_r0", 0, 1, 0, 5'd0, 32'h33, 2'b11, 0);
        bus.io_valid = 1'b0;

        // wb to r0 is no request: md wins
        bus.wb_we = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'hDEAD;
        bus.md_valid = 1'b1; bus.md_reg = 5'd9; bus.md_data = 32'h44;
        step("wb_r0", 1, 0, 1, 5'd9, 32'h44, 2'b10, 0);

        // Starvation: wb wins 4 times, stall on the 5th, wb rewritten on the 6th
        bus.wb_reg = 5'd3; bus.md_reg = 5'd10; bus.md_data = 32'h55;
        for (int i = 0; i < 4; i++) begin
            bus.wb_data = 32'h100 + 32'(i);
            step("starve", 0, 0, 1, 5'd3, 32'h100 + 32'(i), 2'b01, (i == 3));
        end
        step("forced", 1, 0, 1, 5'd10, 32'h55, 2'b10, 0);
        bus.md_valid = 1'b0;
        step("wb_back", 0, 0, 1, 5'd3, 32'h103, 2'b01, 0);

        // Reset mid-handshake; pointer was left pointing at io
        bus.wb_reg = 5'd4; bus.wb_data = 32'h77;
        bus.md_valid = 1'b1; bus.md_reg = 5'd12; bus.md_data = 32'h66;
        step("pre_rst1", 0, 0, 1, 5'd4, 32'h77, 2'b01, 0);
        step("pre_rst2", 0, 0, 1, 5'd4, 32'h77, 2'b01, 0);
        bus.wb_we = 1'b0;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        chk("async_rst.md_ready", 32'(bus.md_ready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        bus.wb_we = 1'b1; bus.wb_data = 32'h78;
        for (int i = 0; i < 4; i++) begin
            step("post_rst", 0, 0, 1, 5'd4, 32'h78, 2'b01, (i == 3));
        end
        bus.io_valid = 1'b1; bus.io_reg = 5'd13; bus.io_data = 32'h88;
        step("post_forced", 1, 0, 1, 5'd12, 32'h66, 2'b10, 0);
        bus.md_valid = 1'b0;
        step("post_wb", 0, 0, 1, 5'd4, 32'h78, 2'b01, 0);
        bus.wb_we = 1'b0;
        step("post_io", 0, 1, 1, 5'd13, 32'h88, 2'b11, 0);
        bus.io_valid = 1'b0;
        step("post_idle", 0, 0, 0, 5'd13, 32'h88, 2'b00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
